// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-LED linear PWM fader for the six active-low board LEDs.
// A 6-bit on/off pattern is accepted over valid/ready while idle. Each LED's level then
// steps one count per fade tick toward 0 or full scale until every LED has settled.
// Optional macro LED_GAMMA_EN: square-law duty, (level*level) >> PWM_BITS, instead of linear.
module led_pwm_fader #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned FADE_DIV = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] pattern_in,
  input  logic       pattern_valid,
  output logic       pattern_ready,
  output logic [5:0] led_n
);

  localparam int unsigned TickW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LevelMax = {PWM_BITS{1'b1}};
  localparam logic [TickW-1:0] TickLast = TickW'(FADE_DIV - 1);

  typedef enum logic [0:0] {StIdle, StFading} state_e;

  state_e              state_q, state_d;
  logic [5:0]          target_q, target_d;
  logic [PWM_BITS-1:0] level_q [6];
  logic [PWM_BITS-1:0] level_d [6];
  logic [PWM_BITS-1:0] duty    [6];
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [TickW-1:0]    tick_cnt_q;
  logic [5:0]          led_n_q, led_n_d;
  logic                step_tick;
  logic                all_settled;

  // Free-running fade prescaler; the tick is its wrap cycle.
  assign step_tick     = (tick_cnt_q == TickLast);
  assign pattern_ready = (state_q == StIdle);
  assign led_n         = led_n_q;

  // Every LED already sits at its goal (registered levels only).
  always_comb begin
    all_settled = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (level_q[i] != (target_q[i] ? LevelMax : '0)) all_settled = 1'b0;
    end
  end

  // Next state: accept in idle, step levels on ticks while fading.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    level_d  = level_q;
    unique case (state_q)
      StIdle: begin
        if (pattern_valid) begin
          target_d = pattern_in;
          state_d  = StFading;
        end
      end
      StFading: begin
        if (all_settled) begin
          state_d = StIdle;
        end else if (step_tick) begin
          for (int i = 0; i < 6; i++) begin
            if (target_q[i] && (level_q[i] != LevelMax)) begin
              level_d[i] = level_q[i] + 1'b1;
            end else if (!target_q[i] && (level_q[i] != '0)) begin
              level_d[i] = level_q[i] - 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq [6];

  // Square-law duty: full-width product, keep the upper half.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      level_sq[i] = (2*PWM_BITS)'(level_q[i]) * (2*PWM_BITS)'(level_q[i]);
      duty[i]     = level_sq[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  // Linear duty.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      duty[i] = level_q[i];
    end
  end
`endif

  // PWM compare; inverted for the active-low pins.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      led_n_d[i] = ~(pwm_cnt_q < duty[i]);
    end
  end

  // State, counters and registered LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      target_q   <= '0;
      pwm_cnt_q  <= '0;
      tick_cnt_q <= '0;
      led_n_q    <= '1;
      for (int i = 0; i < 6; i++) level_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      pwm_cnt_q  <= pwm_cnt_q + 1'b1;
      tick_cnt_q <= step_tick ? '0 : tick_cnt_q + 1'b1;
      led_n_q    <= led_n_d;
      for (int i = 0; i < 6; i++) level_q[i] <= level_d[i];
    end
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader with PWM_BITS=4, FADE_DIV=2: directed steps plus random traffic,
// compared every cycle against a cycle-count based reference model of the fader.
module tb_led_pwm_fader;

  localparam int PwmBits = 4;
  localparam int FadeDiv = 2;
  localparam int Max     = 15;
  localparam int Period  = 16;
`ifdef LED_GAMMA_EN
  localparam int ExpFull = 14;
`else
  localparam int ExpFull = 15;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] pattern_in = '0;
  logic       pattern_valid = 1'b0;
  logic       pattern_ready;
  logic [5:0] led_n;

  int checks = 0;
  int failures = 0;

  led_pwm_fader #(
    .PWM_BITS(PwmBits),
    .FADE_DIV(FadeDiv)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pattern_in   (pattern_in),
    .pattern_valid(pattern_valid),
    .pattern_ready(pattern_ready),
    .led_n        (led_n)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset gives PWM phase and tick phase directly.
  int       m_cyc;
  bit       m_busy;
  bit [5:0] m_target;
  int       m_level [6];
  bit [5:0] m_led_n;

  function automatic int duty_of(input int l);
`ifdef LED_GAMMA_EN
    return (l * l) / Period;
`else
    return l;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    int       lv [6];
    bit       busy;
    bit [5:0] tgt;
    bit [5:0] ln;
    bit       done;
    int       goal;
    if (rst) begin
      m_cyc    <= 0;
      m_busy   <= 1'b0;
      m_target <= '0;
      m_led_n  <= '1;
      for (int i = 0; i < 6; i++) m_level[i] <= 0;
    end else begin
      lv   = m_level;
      busy = m_busy;
      tgt  = m_target;
      for (int i = 0; i < 6; i++) ln[i] = !((m_cyc % Period) < duty_of(m_level[i]));
      if (!busy) begin
        if (pattern_valid) begin
          tgt  = pattern_in;
          busy = 1'b1;
        end
      end else begin
        done = 1'b1;
        for (int i = 0; i < 6; i++) if (lv[i] != (tgt[i] ? Max : 0)) done = 1'b0;
        if (done) begin
          busy = 1'b0;
        end else if ((m_cyc % FadeDiv) == FadeDiv - 1) begin
          for (int i = 0; i < 6; i++) begin
            goal = tgt[i] ? Max : 0;
            if (lv[i] < goal) lv[i] = lv[i] + 1;
            else if (lv[i] > goal) lv[i] = lv[i] - 1;
          end
        end
      end
      m_cyc    <= m_cyc + 1;
      m_busy   <= busy;
      m_target <= tgt;
      m_led_n  <= ln;
      m_level  <= lv;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle_chk();
    @(negedge clk);
    chk("led_n", 32'(led_n), 32'(m_led_n));
    chk("ready", 32'(pattern_ready), 32'(!m_busy));
  endtask

  task automatic run(input int n);
    repeat (n) cycle_chk();
  endtask

  task automatic send(input logic [5:0] p);
    pattern_in    = p;
    pattern_valid = 1'b1;
    cycle_chk();
    pattern_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int used);
    used = 0;
    while (!pattern_ready && used < budget) begin
      cycle_chk();
      used++;
    end
    chk("idle_timeout", 32'(pattern_ready), 32'd1);
  endtask

  task automatic count_low(input int b, output int lows);
    lows = 0;
    repeat (Period) begin
      cycle_chk();
      if (!led_n[b]) lows++;
    end
  endtask

  initial begin
    int used;
    int lows;
    int n;

    // Reset held: pins dark, ready high.
    repeat (5) begin
      @(negedge clk);
      chk("rst_led_n", 32'(led_n), 32'h3f);
      chk("rst_ready", 32'(pattern_ready), 32'd1);
    end
    rst = 1'b0;
    repeat (8) begin
      cycle_chk();
      chk("idle_led_n", 32'(led_n), 32'h3f);
    end

    // Fade-up of LED0.
    send(6'b000001);
    chk("accept_ready_low", 32'(pattern_ready), 32'd0);
    wait_idle(40, used);
    chk("fade_up_in_time", 32'(used + 1 <= 31), 32'd1);
    count_low(0, lows);
    chk("up_duty0", 32'(lows), 32'(ExpFull));
    chk("up_others", 32'(led_n[5:1]), 32'h1f);

    // Mixed: LED0 down, LED1 up concurrently.
    send(6'b000010);
    wait_idle(40, used);
    count_low(0, lows);
    chk("down_led0_off", 32'(lows), 32'd0);
    count_low(1, lows);
    chk("up_duty1", 32'(lows), 32'(ExpFull));

    // Busy: held valid during a fade is taken only once ready rises.
    send(6'b000001);
    run(6);
    pattern_in    = 6'h3f;
    pattern_valid = 1'b1;
    cycle_chk();
    chk("busy_ignored", 32'(pattern_ready), 32'd0);
    wait_idle(40, used);
    cycle_chk();
    chk("busy_reaccept", 32'(pattern_ready), 32'd0);
    pattern_valid = 1'b0;
    wait_idle(40, used);
    count_low(5, lows);
    chk("all_on_duty5", 32'(lows), 32'(ExpFull));

    // Reset mid-fade at level 7.
    send(6'b000000);
    n = 0;
    while (m_level[0] != 7 && n < 60) begin
      cycle_chk();
      n++;
    end
    chk("reach_level7", 32'(n < 60), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_led_n", 32'(led_n), 32'h3f);
    chk("async_ready", 32'(pattern_ready), 32'd1);
    run(2);
    rst = 1'b0;
    repeat (Period) begin
      cycle_chk();
      chk("post_rst_dark", 32'(led_n), 32'h3f);
    end

    // Random traffic, including valid toggling during fades.
    for (int k = 0; k < 12; k++) begin
      send(6'($urandom));
      repeat ($urandom_range(10, 40)) begin
        pattern_valid = 1'($urandom_range(0, 1));
        pattern_in    = 6'($urandom);
        cycle_chk();
      end
      pattern_valid = 1'b0;
      wait_idle(80, used);
      run(int'($urandom_range(0, 20)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
